ps2_transmitter: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.

---
 rtl/ps2_transmitter.sv | 243 ++++++++++++++++++++++++
 tb/tb_ps2_transmitter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 command transmitter.
// Sends one command byte (for example 0xED set-LEDs or 0xFF reset) to a PS/2 keyboard.
// Both PS/2 lines are open-drain, so this block only ever pulls them low via ps2_clk_oe / ps2_data_oe.
// It never drives them high.
// The device generates the bit clock. This block oversamples the line through a synchroniser
// and reacts to the falling edges it sees.
//
// Optional feature macro: PS2_TX_TIMEOUT_EN
//   defined   -> a watchdog aborts a transfer that has not finished TIMEOUT_CYCLES after REQ entry.
//   undefined -> no watchdog; a silent device keeps the block busy until rst.

module ps2_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  // The inhibit phase spans INHIBIT cycles plus the one-cycle REQ.
  // Together they hold the clock low for INHIBIT_CYCLES cycles, so INHIBIT itself lasts
  // INHIBIT_CYCLES-1 cycles. The counter therefore loads INHIBIT_CYCLES-2 and counts down to 0.
  localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LOAD =
    INH_W'((INHIBIT_CYCLES > 1) ? (INHIBIT_CYCLES - 2) : 0);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             bitCnt_q, bitCnt_d;
  logic [8:0]             shift_q, shift_d;
  logic [INH_W-1:0]       inhCnt_q, inhCnt_d;
  logic                   clkOe_q, clkOe_d;
  logic                   dataOe_q, dataOe_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
`ifdef PS2_TX_TIMEOUT_EN
  logic [WD_W-1:0]        wdCnt_q, wdCnt_d;
`endif

  logic [SYNC_STAGES-1:0] clkSync_q;
  logic [SYNC_STAGES-1:0] dataSync_q;
  logic                   clkPrev_q;
  logic                   clkNow;
  logic                   dataNow;
  logic                   clkFall;

  assign clkNow  = clkSync_q[SYNC_STAGES-1];
  assign dataNow = dataSync_q[SYNC_STAGES-1];
  assign clkFall = clkPrev_q & ~clkNow;

  // Bring the asynchronous PS/2 lines into the clk domain.
  // The lines rest high, so the synchroniser resets to 1 and reset cannot fake a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clkSync_q  <= '1;
      dataSync_q <= '1;
      clkPrev_q  <= 1'b1;
    end else begin
      clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], ps2_clk_in};
      dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], ps2_data_in};
      clkPrev_q  <= clkNow;
    end
  end

  // Next-state and registered-output logic for the transfer sequence.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    inhCnt_d = inhCnt_q;
    clkOe_d  = clkOe_q;
    dataOe_d = dataOe_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    wdCnt_d  = wdCnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        clkOe_d  = 1'b0;
        dataOe_d = 1'b0;
        bitCnt_d = 4'd0;
`ifdef PS2_TX_TIMEOUT_EN
        wdCnt_d  = '0;
`endif
        if (tx_valid && ready_q) begin
          state_d  = S_INHIBIT;
          shift_d  = {~^tx_data, tx_data};
          inhCnt_d = INH_LOAD;
          clkOe_d  = 1'b1;
        end
      end

      S_INHIBIT: begin
        clkOe_d  = 1'b1;
        dataOe_d = 1'b0;
        if (inhCnt_q == '0) begin
          state_d  = S_REQ;
          dataOe_d = 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
          wdCnt_d  = WD_W'(1);
`endif
        end else begin
          inhCnt_d = inhCnt_q - INH_W'(1);
        end
      end

      S_REQ: begin
        state_d  = S_SEND;
        clkOe_d  = 1'b0;
        dataOe_d = 1'b1;
      end

      S_SEND: begin
        clkOe_d = 1'b0;
        if (clkFall) begin
          bitCnt_d = bitCnt_q + 4'd1;
          if (bitCnt_q < 4'd9) begin
            dataOe_d = ~shift_q[0];
            shift_d  = {1'b0, shift_q[8:1]};
          end else begin
            dataOe_d = 1'b0;
            state_d  = S_ACK;
          end
        end
      end

      S_ACK: begin
        clkOe_d  = 1'b0;
        dataOe_d = 1'b0;
        if (clkFall) begin
          if (!dataNow) begin
            state_d = S_WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        clkOe_d  = 1'b0;
        dataOe_d = 1'b0;
        if (clkNow && dataNow) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d  = S_IDLE;
        clkOe_d  = 1'b0;
        dataOe_d = 1'b0;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    if (state_q == S_REQ || state_q == S_SEND ||
        state_q == S_ACK || state_q == S_WAIT_IDLE) begin
      if (wdCnt_q >= WD_W'(TIMEOUT_CYCLES)) begin
        state_d  = S_IDLE;
        clkOe_d  = 1'b0;
        dataOe_d = 1'b0;
        done_d   = 1'b0;
        error_d  = 1'b1;
      end else begin
        wdCnt_d  = wdCnt_q + WD_W'(1);
      end
    end
`endif

    // Holding ready low during the done/error pulse makes ready rise one cycle after it.
    ready_d = (state_d == S_IDLE) && !done_d && !error_d;
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; reset releases both lines on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bitCnt_q <= 4'd0;
      shift_q  <= 9'd0;
      inhCnt_q <= '0;
      clkOe_q  <= 1'b0;
      dataOe_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wdCnt_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      inhCnt_q <= inhCnt_d;
      clkOe_q  <= clkOe_d;
      dataOe_q <= dataOe_d;
      done_q   <= done_d;
      error_q  <= error_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef PS2_TX_TIMEOUT_EN
      wdCnt_q  <= wdCnt_d;
`endif
    end
  end

  assign tx_ready    = ready_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clkOe_q;
  assign ps2_data_oe = dataOe_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Testbench for ps2_transmitter with a behavioural PS/2 keyboard on the shared open-drain lines.
// Expected frames and results are queued as each command is issued.
// The keyboard model and the pulse monitor pop those queues and compare independently of the stimulus.

module tb_ps2_transmitter;

  localparam int INHIBIT     = 8;
  localparam int TIMEOUT     = 400;
  localparam int HALF        = 10;
  localparam int MODE_ACK    = 0;
  localparam int MODE_NACK   = 1;
  localparam int MODE_SILENT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  logic       devClkLow = 1'b0;
  logic       devDataLow = 1'b0;
  logic       ps2ClkLine;
  logic       ps2DataLine;

  int         testsRun = 0;
  int         testsFailed = 0;
  int         pulseCount = 0;
  int         devFalls = 0;
  int         devMode = MODE_ACK;
  logic       devAbort = 1'b0;

  logic        expResQ[$];
  logic [10:0] expFrameQ[$];

  // Open-drain wiring: a line is high unless someone pulls it low.
  assign ps2ClkLine  = ~(ps2_clk_oe | devClkLow);
  assign ps2DataLine = ~(ps2_data_oe | devDataLow);

  ps2_transmitter #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk_in(ps2ClkLine),
    .ps2_data_in(ps2DataLine),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .tx_done(tx_done),
    .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitPulse(input int startCount);
    int n;
    n = 0;
    while (pulseCount == startCount && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (pulseCount == startCount) checkOutput("completionTimeout", 32'd0, 32'd1);
    repeat (30) @(negedge clk);
  endtask

  // parity is the hand-computed odd-parity bit; frame bit 0 is the start bit.
  task automatic applyStimulus(input logic [7:0] d, input logic par, input int mode,
                               input logic expectErr);
    int startCount;
    @(negedge clk);
    devMode  = mode;
    tx_data  = d;
    tx_valid = 1'b1;
    expFrameQ.push_back({1'b1, par, d, 1'b0});
    expResQ.push_back(expectErr);
    startCount = pulseCount;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~d;
    checkOutput("busyAfterAccept", {30'd0, busy, tx_ready}, 32'b10);
    waitPulse(startCount);
  endtask

  // Keyboard model: once the host releases clock with the start bit low, it clocks 11 pulses.
  // Each pulse is 20 clk long. The model samples data on rising edges and ACKs at pulse 11.
  initial begin : deviceModel
    int dState;
    int waitCnt;
    int phase;
    int pulse;
    logic [10:0] frame;
    dState = 0;
    waitCnt = 0;
    phase = 0;
    pulse = 0;
    frame = '0;
    forever begin
      @(negedge clk);
      if (devAbort) begin
        devClkLow  = 1'b0;
        devDataLow = 1'b0;
        dState     = 0;
        waitCnt    = 0;
        devFalls   = 0;
        devAbort   = 1'b0;
      end else begin
        case (dState)
          0: begin
            if (ps2ClkLine && !ps2DataLine && !ps2_clk_oe) waitCnt++;
            else waitCnt = 0;
            if (waitCnt == 5) begin
              waitCnt = 0;
              if (devMode == MODE_SILENT) begin
                dState = 2;
              end else begin
                frame    = '0;
                frame[0] = ps2DataLine;
                phase    = 0;
                pulse    = 1;
                devFalls = 0;
                dState   = 1;
              end
            end
          end
          1: begin
            if (phase == 0) begin
              devClkLow = 1'b1;
              devFalls  = pulse;
            end else if (phase == HALF) begin
              devClkLow = 1'b0;
              if (pulse <= 10) frame[pulse] = ps2DataLine;
              if (pulse == 10) begin
                if (expFrameQ.size() == 0) begin
                  checkOutput("unexpectedFrame", {21'd0, frame}, 32'd0);
                end else begin
                  checkOutput("frame", {21'd0, frame}, {21'd0, expFrameQ.pop_front()});
                end
              end
            end else if (phase == HALF + 5 && pulse == 10 && devMode == MODE_ACK) begin
              devDataLow = 1'b1;
            end else if (phase == HALF + 3 && pulse == 11) begin
              devDataLow = 1'b0;
            end
            phase++;
            if (phase == 2 * HALF) begin
              phase = 0;
              pulse++;
              if (pulse == 12) dState = 0;
            end
          end
          default: begin
            if (ps2DataLine) dState = 0;
          end
        endcase
      end
    end
  end

  // Scoreboard monitor: every done/error pulse is matched against the queued expected outcome.
  initial begin : pulseMonitor
    logic e;
    forever begin
      @(negedge clk);
      if (!rst && (tx_done || tx_error)) begin
        pulseCount++;
        if (expResQ.size() == 0) begin
          checkOutput("unexpectedPulse", {30'd0, tx_error, tx_done}, 32'd0);
        end else begin
          e = expResQ.pop_front();
          checkOutput("pulseKind", {30'd0, tx_error, tx_done}, e ? 32'b10 : 32'b01);
        end
        checkOutput("linesReleasedAtPulse", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        checkOutput("readyLowInPulse", {31'd0, tx_ready}, 32'd0);
        @(negedge clk);
        checkOutput("pulseOneCycle", {28'd0, tx_error, tx_done, tx_ready, busy}, 32'b0010);
      end
    end
  end

  // Each contiguous clock-inhibit stretch must be exactly INHIBIT cycles long.
  initial begin : inhibitMonitor
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (ps2_clk_oe) begin
        run++;
      end else begin
        if (run != 0) checkOutput("inhibitLength", run, INHIBIT);
        run = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL globalTimeout: got timeout expected finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin : mainSeq
    int n;
    int startCount;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetState", {26'd0, ps2_clk_oe, ps2_data_oe, busy, tx_ready, tx_done, tx_error},
                32'b000100);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic transfers with ACK; the expected parity bits are hand-computed.
    applyStimulus(8'hED, 1'b1, MODE_ACK, 1'b0);
    applyStimulus(8'h01, 1'b0, MODE_ACK, 1'b0);
    applyStimulus(8'h00, 1'b1, MODE_ACK, 1'b0);

    // NACK from the device.
    applyStimulus(8'h5A, 1'b1, MODE_NACK, 1'b1);

    // Reset mid-transfer at k=5 (0xA5 bit 4 is 0, so the data line is being pulled low).
    @(negedge clk);
    devMode  = MODE_ACK;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (devFalls != 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachedFall5", {31'd0, devFalls == 5}, 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("dataDrivenAtK5", {31'd0, ps2_data_oe}, 32'd1);
    rst      = 1'b1;
    devAbort = 1'b1;
    @(negedge clk);
    checkOutput("midResetRelease",
                {26'd0, ps2_clk_oe, ps2_data_oe, busy, tx_ready, tx_done, tx_error}, 32'b000100);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    applyStimulus(8'hFF, 1'b1, MODE_ACK, 1'b0);

    // tx_valid held high with changing tx_data: only the first byte (0x3C) is sent.
    @(negedge clk);
    devMode  = MODE_ACK;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    expFrameQ.push_back({1'b1, 1'b1, 8'h3C, 1'b0});
    expResQ.push_back(1'b0);
    startCount = pulseCount;
    n = 0;
    do begin
      @(negedge clk);
      tx_data = tx_data + 8'h11;
      n++;
    end while (!(tx_done || tx_error) && n < 3000);
    tx_valid = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("heldValidSinglePulse", pulseCount - startCount, 32'd1);

    // Silent device.
    @(negedge clk);
    devMode  = MODE_SILENT;
    tx_data  = 8'h12;
    tx_valid = 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
    expResQ.push_back(1'b1);
`endif
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (!ps2_data_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reqSeen", {31'd0, ps2_data_oe}, 32'd1);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (!tx_error && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeoutLatency", n, TIMEOUT);
    repeat (30) @(negedge clk);
`else
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!busy || tx_done || tx_error) n++;
    end
    checkOutput("silentBusyHeld", n, 32'd0);
    rst      = 1'b1;
    devAbort = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
`endif

    // Recovery after the silent device.
    applyStimulus(8'hF0, 1'b1, MODE_ACK, 1'b0);
    checkOutput("queuesDrained", expResQ.size() + expFrameQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
